// File: rtl/riscv_loader_pkg.sv
// Shared definitions for the serial program loader.
//   loader_state_e : FSM state encoding used by program_loader
//   SYNC_BYTE      : frame start marker
//   LEN_W          : width of the word-count field in the frame header
package riscv_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SYNC,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned LEN_W     = 16;

endpackage

// File: rtl/loader_word_assembler.sv
// Collects four bytes (least-significant first) into a 32-bit instruction.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : restart at byte 0 (start of a new load)
//   byte_valid   : byte_data is accepted this cycle
//   byte_data    : incoming byte
//   word_valid   : the 4th byte of a word is being accepted this cycle
//   word         : assembled word, valid together with word_valid
module loader_word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [23:0] low;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      idx <= '0;
    end else if (byte_valid) begin
      idx <= idx + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      low <= '0;
    end else if (byte_valid) begin
      case (idx)
        2'd0:    low[7:0]   <= byte_data;
        2'd1:    low[15:8]  <= byte_data;
        2'd2:    low[23:16] <= byte_data;
        default: ;
      endcase
    end
  end

  // The top byte is taken straight from the input so the word can be
  // registered by the caller in the same cycle its last byte arrives.
  always_comb begin
    word_valid = byte_valid && (idx == 2'd3);
    word       = {byte_data, low};
  end

endmodule

// File: rtl/program_loader.sv
// Serial program loader for the instruction memory of the 8-bit RISC-V core.
// Frame: 0xA5, 16-bit word count (LSB first), N words (LSB first), and a
// trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
// Ports:
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   start           : one-cycle load request (ignored while busy)
//   rx_valid/rx_data: received byte stream, one byte per cycle, no backpressure
//   rw              : instruction memory write strobe
//   reset_IF_memory : one-cycle instruction memory clear pulse
//   PC_write        : instruction write address
//   instruction_in  : instruction to write
//   core_reset      : holds the pipeline in reset during/after a failed load
//   busy/done/error : load status
module program_loader
  import riscv_loader_pkg::*;
#(
  parameter int unsigned PC_SIZE        = 10,
  parameter int unsigned ADDR_STEP      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rw,
  output logic               reset_IF_memory,
  output logic [PC_SIZE-1:0] PC_write,
  output logic [31:0]        instruction_in,
  output logic               core_reset,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int unsigned MAX_WORDS = (32'd1 << PC_SIZE) / ADDR_STEP;
  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam loader_state_e LOAD_END = ST_CHECK;
`else
  localparam loader_state_e LOAD_END = ST_DONE;
`endif

  loader_state_e    state, state_next;
  logic             in_frame, accept, timed_out;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] len, remaining;
  logic [TW-1:0]    timer, timer_nxt;
  logic             word_valid;
  logic [31:0]      word;

  always_comb begin
    in_frame  = state inside {ST_SYNC, ST_LEN0, ST_LEN1, ST_DATA, ST_CHECK};
    accept    = rx_valid && in_frame;
    len       = {rx_data, len_lo};
    timer_nxt = timer + TW'(1);
    timed_out = in_frame && !accept && (timer_nxt == TW'(TIMEOUT_CYCLES));
  end

  loader_word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (state == ST_CLEAR),
    .byte_valid (accept && (state == ST_DATA)),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clock) begin
    if (reset || state == ST_CLEAR) begin
      csum <= '0;
    end else if (accept && (state inside {ST_LEN0, ST_LEN1, ST_DATA})) begin
      csum <= csum ^ rx_data;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_next = ST_CLEAR;
      ST_CLEAR: state_next = ST_SYNC;
      ST_SYNC:  if (accept) state_next = (rx_data == SYNC_BYTE) ? ST_LEN0 : ST_ERROR;
      ST_LEN0:  if (accept) state_next = ST_LEN1;
      ST_LEN1: begin
        if (accept) begin
          if (32'(len) > MAX_WORDS) state_next = ST_ERROR;
          else if (len == '0)       state_next = LOAD_END;
          else                      state_next = ST_DATA;
        end
      end
      ST_DATA: if (word_valid && remaining == LEN_W'(1)) state_next = LOAD_END;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK: if (accept) state_next = (rx_data == csum) ? ST_DONE : ST_ERROR;
`endif
      default: state_next = ST_IDLE;
    endcase
    if (timed_out) state_next = ST_ERROR;
  end

  // Status outputs are registered from the next state so they change in the
  // same cycle the FSM enters the corresponding state.
  always_ff @(posedge clock) begin
    if (reset) begin
      rw              <= 1'b0;
      reset_IF_memory <= 1'b0;
      core_reset      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      PC_write        <= '0;
      instruction_in  <= '0;
      len_lo          <= '0;
      remaining       <= '0;
      timer           <= '0;
    end else begin
      rw              <= word_valid;
      reset_IF_memory <= (state_next == ST_CLEAR);
      busy            <= !(state_next inside {ST_IDLE, ST_DONE, ST_ERROR});
      done            <= (state_next == ST_DONE);
      error           <= (state_next == ST_ERROR);
      core_reset      <= !(state_next inside {ST_IDLE, ST_DONE});

      if (word_valid) instruction_in <= word;

      // Address moves on after the write strobe has been seen by the memory.
      if (state_next == ST_CLEAR) PC_write <= '0;
      else if (rw)                PC_write <= PC_write + PC_SIZE'(ADDR_STEP);

      if (accept && state == ST_LEN0) len_lo <= rx_data;

      if (accept && state == ST_LEN1) remaining <= len;
      else if (word_valid)            remaining <= remaining - LEN_W'(1);

      // timer = cycles since the last accepted byte, so the error appears
      // exactly TIMEOUT_CYCLES cycles after that byte.
      if (!in_frame || accept) timer <= TW'(1);
      else                     timer <= timer_nxt;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int unsigned PCW = 10;
  localparam int unsigned MAXW = (1 << PCW) / 4;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           rx_valid = 1'b0;
  logic [7:0]     rx_data = '0;
  logic           rw, reset_IF_memory, core_reset, busy, done, error;
  logic [PCW-1:0] PC_write;
  logic [31:0]    instruction_in;

  program_loader #(
    .PC_SIZE        (PCW),
    .ADDR_STEP      (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .rw              (rw),
    .reset_IF_memory (reset_IF_memory),
    .PC_write        (PC_write),
    .instruction_in  (instruction_in),
    .core_reset      (core_reset),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  frame[$];
  logic [41:0] exp_writes[$];
  logic [41:0] wr_seen[$];
  bit          exp_done, exp_err;
  int          gap_max = 0;

  typedef struct {
    int unsigned len;
    logic [7:0]  b [12];
    bit          done;
    bit          err;
    int unsigned nw;
  } vec_t;
  vec_t vecs[6];

  always @(negedge clock) if (rw === 1'b1) wr_seen.push_back({PC_write, instruction_in});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  function automatic logic [7:0] xor_tail();
    logic [7:0] x = '0;
    for (int i = 1; i < frame.size(); i++) x ^= frame[i];
    return x;
  endfunction

  // Reference: interpret a frame by the framing rules alone.
  task automatic model();
    int unsigned n;
    logic [7:0]  x;
    exp_writes.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (frame.size() < 3 || frame[0] != 8'hA5) begin
      exp_err = 1'b1;
      return;
    end
    n = {frame[2], frame[1]};
    if (n > MAXW) begin
      exp_err = 1'b1;
      return;
    end
    for (int unsigned w = 0; w < n; w++)
      exp_writes.push_back({PCW'((4 * w) % (1 << PCW)), frame[3+4*w+3], frame[3+4*w+2],
                            frame[3+4*w+1], frame[3+4*w]});
    if (CS_EN) begin
      x = '0;
      for (int unsigned i = 1; i < 3 + 4 * n; i++) x ^= frame[i];
      if (frame[3+4*n] == x) exp_done = 1'b1;
      else                   exp_err  = 1'b1;
    end else begin
      exp_done = 1'b1;
    end
  endtask

  task automatic build_frame(input int unsigned n, input int kind);
    logic [7:0] b;
    frame.delete();
    if (kind == 1) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h00;
      frame.push_back(b);
    end else begin
      frame.push_back(8'hA5);
    end
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
    if (n <= MAXW) for (int unsigned i = 0; i < 4 * n; i++) frame.push_back(8'($urandom_range(0, 255)));
    if (CS_EN) begin
      b = xor_tail();
      if (kind == 3) b ^= 8'($urandom_range(1, 255));
      frame.push_back(b);
    end
  endtask

  task automatic run_frame(input string tag, input int start_at);
    int guard;
    wr_seen.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " start"}, {reset_IF_memory, busy, core_reset, done, error, PC_write},
          {5'b11100, PCW'(0)});
    tick();
    check({tag, " clr once"}, reset_IF_memory, 1'b0);
    foreach (frame[i]) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
      rx_valid = 1'b1;
      rx_data  = frame[i];
      start    = (i == start_at);
      tick();
      rx_valid = 1'b0;
      start    = 1'b0;
    end
    guard = 0;
    while (busy && guard < 40) begin
      tick();
      guard++;
    end
    check({tag, " terminated"}, busy, 1'b0);
    repeat (2) tick();
    check({tag, " done"}, done, exp_done);
    check({tag, " error"}, error, exp_err);
    check({tag, " core_reset"}, core_reset, !exp_done);
    check({tag, " nwrites"}, wr_seen.size(), exp_writes.size());
    for (int i = 0; i < exp_writes.size() && i < wr_seen.size(); i++)
      check($sformatf("%s write%0d", tag, i), wr_seen[i], exp_writes[i]);
  endtask

  initial begin
    vecs[0] = '{11, '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'h00}, 1'b1, 1'b0, 2};
    vecs[1] = '{1,  '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 0};
    vecs[2] = '{3,  '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 0};
    vecs[3] = '{3,  '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 0};
    vecs[4] = '{7,  '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 1};
    vecs[5] = '{3,  '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 0};

    repeat (3) tick();
    check("reset state", {rw, reset_IF_memory, core_reset, busy, done, error, PC_write, instruction_in},
          '0);
    reset = 1'b0;
    tick();
    check("idle state", {core_reset, busy, done, error}, 4'b0000);

    // Table-driven frames
    foreach (vecs[v]) begin
      frame.delete();
      for (int unsigned i = 0; i < vecs[v].len; i++) frame.push_back(vecs[v].b[i]);
      if (CS_EN) frame.push_back(xor_tail());
      model();
      run_frame($sformatf("vec%0d", v), -1);
      check($sformatf("vec%0d tbl done", v), done, vecs[v].done);
      check($sformatf("vec%0d tbl error", v), error, vecs[v].err);
      check($sformatf("vec%0d tbl nw", v), wr_seen.size(), vecs[v].nw);
    end

    // Write strobe and address timing for a single word
    wr_seen.delete();
    do_start();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("rw pulse", rw, 1'b1);
    check("rw data", instruction_in, 32'h44332211);
    check("rw addr", PC_write, 0);
    check("last word status", {busy, done}, {CS_EN, !CS_EN});
    tick();
    check("rw one cycle", rw, 1'b0);
    check("addr advance", PC_write, 4);
    if (CS_EN) send_byte(8'h01 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
    check("single word done", {done, error, core_reset}, 3'b100);

    // Timeout after two data bytes
    wr_seen.delete();
    do_start();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
    repeat (14) tick();
    check("timeout early", {busy, error}, 2'b10);
    tick();
    check("timeout fire", {busy, error, core_reset, done}, 4'b0110);
    check("timeout no rw", wr_seen.size(), 0);

    // Reset in the middle of a load, then reload
    wr_seen.delete();
    do_start();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    check("mid rw", {rw, PC_write, instruction_in}, {1'b1, PCW'(0), 32'h00100013});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid reset outs", {rw, reset_IF_memory, core_reset, busy, done, error, PC_write, instruction_in},
          '0);
    frame.delete();
    for (int unsigned i = 0; i < vecs[0].len; i++) frame.push_back(vecs[0].b[i]);
    if (CS_EN) frame.push_back(xor_tail());
    model();
    run_frame("reload", -1);

    // start while busy must be ignored
    frame.delete();
    for (int unsigned i = 0; i < vecs[4].len; i++) frame.push_back(vecs[4].b[i]);
    if (CS_EN) frame.push_back(xor_tail());
    model();
    run_frame("busy start", 2);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    frame.delete();
    for (int unsigned i = 0; i < vecs[0].len; i++) frame.push_back(vecs[0].b[i]);
    frame.push_back(8'hB1);
    model();
    run_frame("bad csum", -1);
    check("bad csum state", {error, core_reset, done}, 3'b110);
    check("bad csum writes", wr_seen.size(), 2);
`endif

    // Largest legal frame fills the whole memory
    build_frame(MAXW, 0);
    model();
    run_frame("max len", -1);

    // Randomised frames with gaps and ignored traffic outside a load
    for (int it = 0; it < 25; it++) begin
      int kind;
      int unsigned n;
      kind = $urandom_range(0, 9);
      n = (kind == 1 && $urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 6);
      if (kind == 2) n = $urandom_range(MAXW + 1, 65535);
      build_frame(n, (kind == 0) ? 1 : (kind == 2) ? 2 : (kind == 3) ? 3 : 0);
      model();
      repeat ($urandom_range(0, 3)) begin
        rx_valid = 1'b1;
        rx_data  = 8'($urandom_range(0, 255));
        tick();
      end
      rx_valid = 1'b0;
      gap_max = $urandom_range(0, 3);
      run_frame($sformatf("rand%0d", it), -1);
    end
    gap_max = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
